// File: rtl/sdram_port.sv
// Initiator-side adapter for the sdram_bus toggle handshake: valid/ready commands in, one request in flight.
// Define SDRAM_PORT_FIFO_EN to add the DEPTH-entry command queue; otherwise only the direct issue path exists.
module sdram_port #(
  parameter int ADDR_BITS = 22,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [15:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy,
  output logic                 bus_req,
  output logic [ADDR_BITS-1:0] bus_address,
  output logic                 bus_we,
  output logic [15:0]          bus_data_write,
  input  logic                 bus_ack,
  input  logic [15:0]          bus_data_read
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = ADDR_BITS + 17;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_WAIT} state_e;

  state_e                 state_q;
  logic                   req_q, we_q, rsp_valid_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            wdata_q, rsp_data_q;
  logic [PW:0]            count;
  logic                   accept, done, issue;
  logic [EW-1:0]          cmd_ent, iss_ent;

  assign cmd_ent = {cmd_we, cmd_addr, cmd_wdata};
  assign accept  = cmd_valid && cmd_ready;
  assign done    = (state_q == S_WAIT) && (bus_ack == req_q);

`ifdef SDRAM_PORT_FIFO_EN
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          push, pop, bypass;

  assign count     = cnt_q;
  // Ready uses the registered count, so a full queue stays closed even on a pop cycle.
  assign cmd_ready = (state_q != S_SYNC) && (cnt_q < (PW+1)'(DEPTH));
  assign pop       = (cnt_q != '0) && ((state_q == S_IDLE) || done);
  assign bypass    = (state_q == S_IDLE) && (cnt_q == '0) && accept;
  assign push      = accept && !bypass;
  assign issue     = pop || bypass;
  assign iss_ent   = pop ? mem_q[rptr_q] : cmd_ent;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`else
  assign count     = '0;
  assign cmd_ready = (state_q == S_IDLE);
  assign issue     = accept;
  assign iss_ent   = cmd_ent;
`endif

  assign busy = (state_q == S_WAIT) || (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SYNC;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (issue) begin
        req_q                     <= ~req_q;
        {we_q, addr_q, wdata_q}   <= iss_ent;
      end
      case (state_q)
        // Realign req to whatever ack the controller left behind, abandoning any old request.
        S_SYNC: begin
          req_q   <= bus_ack;
          state_q <= S_IDLE;
        end
        S_IDLE: if (issue) state_q <= S_WAIT;
        S_WAIT: if (done) begin
          if (!we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus_data_read;
          end
          if (!issue) state_q <= S_IDLE;
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign bus_req        = req_q;
  assign bus_address    = addr_q;
  assign bus_we         = we_q;
  assign bus_data_write = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;

endmodule
